imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 14 +
 rtl/imem_loader_if.sv | 18 +
 rtl/imem_word_asm.sv | 40 ++++
 rtl/imem_loader.sv | 104 ++++++++++
 tb/tb_imem_loader.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   IMEM_DEPTH : default number of 32-bit words in IMEM
//   IMEM_AW    : IMEM word-address width
//   IMEM_HALT  : halt instruction (beq x0,x0,0) used to fill unused IMEM
//   ld_state_t : loader FSM state encoding
package imem_loader_pkg;
  localparam int          IMEM_DEPTH = 128;
  localparam int          IMEM_AW    = 7;
  localparam logic [31:0] IMEM_HALT  = 32'h0000_0063;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_FILL, S_DONE, S_ERR
  } ld_state_t;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream in / IMEM write port out bundle for the loader.
//   rx_valid, rx_data : byte stream from the serial receiver
//   rx_ready          : loader takes the byte when rx_valid && rx_ready
//   imem_we/waddr/wdata : IMEM write port
// master = stream source / IMEM side, slave = loader.
interface imem_loader_if import imem_loader_pkg::*; #(parameter int AW = IMEM_AW);
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;

  modport master (output rx_valid, rx_data,
                  input  rx_ready, imem_we, imem_waddr, imem_wdata);
  modport slave  (input  rx_valid, rx_data,
                  output rx_ready, imem_we, imem_waddr, imem_wdata);
endinterface

// File: rtl/imem_word_asm.sv
// Little-endian 4-byte word assembler.
//   clk, rst_n  : clock, async active-low reset
//   clear       : zero the word and byte counter (start of a new load)
//   load        : take byte_in into lane byte_cnt
//   byte_in     : incoming byte
//   word        : assembled word (byte k in bits 8k+7:8k)
//   last        : comb, this load completes the word
//   word_valid  : registered, high the cycle after the 4th byte is taken
module imem_word_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last,
  output logic        word_valid
);
  logic [1:0] byte_cnt;

  assign last = load && (byte_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word       <= '0;
      byte_cnt   <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      word       <= '0;
      byte_cnt   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= last;
      if (load) begin
        word[{byte_cnt, 3'b000} +: 8] <= byte_in;
        byte_cnt <= byte_cnt + 2'd1;  // wraps to 0 after the 4th byte
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Program loader: receives a 16-bit little-endian word count followed by
// count*4 bytes, writes the words to IMEM from address 0, then fills the
// rest of IMEM with HALT_INSTR. CPU is held while loading and on error.
//   clk, rst_n : clock, async active-low reset
//   start      : load request pulse (honoured in IDLE/DONE/ERR only)
//   cpu_hold   : CPU held in reset/stall
//   busy       : load in progress
//   done       : load finished
//   error      : bad word count (0 or larger than DEPTH)
//   bus        : byte stream in, IMEM write port out
module imem_loader import imem_loader_pkg::*; #(
  parameter int          DEPTH      = IMEM_DEPTH,
  parameter logic [31:0] HALT_INSTR = IMEM_HALT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic cpu_hold,
  output logic busy,
  output logic done,
  output logic error,
  imem_loader_if.slave bus
);
  localparam int            AW        = IMEM_AW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [15:0]   DEPTH16   = 16'(DEPTH);

  ld_state_t     state, state_nxt;
  logic [15:0]   count;
  logic [AW-1:0] waddr;
  logic [31:0]   asm_word;
  logic          asm_last, asm_valid;

  logic        idle_like, hs, start_ok, last_word, fill_empty;
  logic [15:0] len_full;

  assign idle_like  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign start_ok   = start && idle_like;
  assign hs         = bus.rx_valid && bus.rx_ready;
  assign len_full   = {bus.rx_data, count[7:0]};  // count as it will be after LEN1
  assign last_word  = (16'(waddr) + 16'd1) == count;
  // Full-depth program: nothing left to fill.
  assign fill_empty = (count == DEPTH16);

  imem_word_asm u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .load       (hs && (state == S_DATA)),
    .byte_in    (bus.rx_data),
    .word       (asm_word),
    .last       (asm_last),
    .word_valid (asm_valid)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LEN0;
      S_LEN0:  if (hs) state_nxt = S_LEN1;
      S_LEN1:  if (hs) state_nxt = ((len_full == 16'd0) || (len_full > DEPTH16)) ? S_ERR : S_DATA;
      S_DATA:  if (asm_last) state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_word ? S_FILL : S_DATA;
      S_FILL:  if (fill_empty || (waddr == LAST_ADDR)) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Word count and write address. The address saturates at LAST_ADDR so
  // a full-depth load never wraps back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      waddr <= '0;
    end else if (start_ok) begin
      count <= '0;
      waddr <= '0;
    end else begin
      if (state == S_LEN0 && hs) count[7:0]  <= bus.rx_data;
      if (state == S_LEN1 && hs) count[15:8] <= bus.rx_data;
      if (((state == S_WRITE) || (state == S_FILL && !fill_empty)) && (waddr != LAST_ADDR))
        waddr <= waddr + 1'b1;
    end
  end

  // Outputs
  always_comb begin
    bus.rx_ready   = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA);
    bus.imem_we    = ((state == S_WRITE) && asm_valid) || ((state == S_FILL) && !fill_empty);
    bus.imem_waddr = waddr;
    bus.imem_wdata = (state == S_FILL) ? HALT_INSTR : asm_word;
    cpu_hold       = !((state == S_IDLE) || (state == S_DONE));
    busy           = !idle_like;
    done           = (state == S_DONE);
    error          = (state == S_ERR);
  end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected IMEM writes,
// a negedge monitor pops and compares every imem_we cycle.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic cpu_hold, busy, done, error;

  imem_loader_if bus();

  imem_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  total = 0, bad = 0;
  int  hs_n = 0;
  bit  lat_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] stat();
    return {bus.rx_ready, bus.imem_we, busy, done, error, cpu_hold};
  endfunction

  // Monitor: scoreboard pop on every write; write-latency check one cycle
  // after the 4th byte of each word is accepted.
  always @(negedge clk) begin
    if (lat_chk) check("write_latency", 32'(bus.imem_we), 32'd1);
    lat_chk = 1'b0;
    if (start) hs_n = 0;
    if (rst_n && bus.rx_valid && bus.rx_ready) begin
      if (hs_n >= 2 && ((hs_n - 2) % 4) == 3) lat_chk = 1'b1;
      hs_n++;
    end
    if (bus.imem_we) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: addr %0d data %h, none queued", bus.imem_waddr, bus.imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bus.imem_waddr), 32'(mon_e.addr));
        check("wr_data", bus.imem_wdata, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic push_wr(input int a, input logic [31:0] d);
    wr_t w;
    w.addr = 7'(a);
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic push_fill(input int from);
    for (int a = from; a < 128; a++) push_wr(a, 32'h0000_0063);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int k;
    if (gaps) begin
      k = $urandom_range(0, 2);
      bus.rx_valid = 1'b0;
      repeat (k) tick();
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rx_ready) begin
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        return;
      end
    end
    total++; bad++;
    $display("FAIL send_timeout: byte %h not accepted", b);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
  endtask

  task automatic wait_end();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done || error) begin
        tick();
        return;
      end
    end
    total++; bad++;
    $display("FAIL end_timeout: done/error never rose");
    tick();
  endtask

  task automatic expect_done(input string tag);
    check({tag, "_done"}, 32'({done, error, cpu_hold, busy}), 32'b1000);
    check({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic expect_err(input string tag);
    check({tag, "_err"}, 32'({done, error, cpu_hold, busy}), 32'b0110);
    check({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset state
    #2;
    check("rst_status", 32'(stat()), 32'd0);
    check("rst_waddr", 32'(bus.imem_waddr), 32'd0);
    check("rst_wdata", bus.imem_wdata, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("idle_status", 32'(stat()), 32'd0);

    // Two-word program, then fill
    push_wr(0, 32'h0000_0013);
    push_wr(1, 32'h0010_0093);
    push_fill(2);
    pulse_start();
    check("load_hold_busy", 32'({cpu_hold, busy, bus.rx_ready}), 32'b111);
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    wait_end();
    expect_done("basic");
    repeat (5) tick();
    check("done_persist", 32'(done), 32'd1);

    // Zero count -> ERR, then recover
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    wait_end();
    expect_err("zero_cnt");
    repeat (3) tick();
    check("err_persist", 32'(error), 32'd1);
    push_wr(0, 32'hDDCC_BBAA);
    push_fill(1);
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    wait_end();
    expect_done("recover");

    // Count 129 -> ERR; count 128 -> full program, no fill
    pulse_start();
    send_byte(8'h81, 0); send_byte(8'h00, 0);
    wait_end();
    expect_err("cnt129");
    for (int i = 0; i < 128; i++)
      push_wr(i, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    pulse_start();
    send_byte(8'h80, 0); send_byte(8'h00, 0);
    for (int i = 0; i < 512; i++) send_byte(8'(i), 0);
    wait_end();
    expect_done("cnt128");

    // Stalling stream: random rx_valid gaps
    push_wr(0, 32'h1122_3344);
    push_wr(1, 32'hA5A5_5A5A);
    push_wr(2, 32'hDEAD_BEEF);
    push_fill(3);
    pulse_start();
    send_byte(8'h03, 1); send_byte(8'h00, 1);
    send_word(32'h1122_3344, 1);
    send_word(32'hA5A5_5A5A, 1);
    send_word(32'hDEAD_BEEF, 1);
    wait_end();
    expect_done("gaps");

    // Reset after 6 data bytes of a 2-word load
    push_wr(0, 32'h0403_0201);
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_status", 32'(stat()), 32'd0);
    check("midrst_waddr", 32'(bus.imem_waddr), 32'd0);
    check("midrst_wdata", bus.imem_wdata, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("midrst_idle", 32'(stat()), 32'd0);
    check("midrst_queue", 32'(exp_q.size()), 32'd0);
    push_wr(0, 32'hCAFE_F00D);
    push_wr(1, 32'h0000_0001);
    push_fill(2);
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(32'hCAFE_F00D, 0);
    send_word(32'h0000_0001, 0);
    wait_end();
    expect_done("after_rst");

    // start during FILL is ignored
    push_wr(0, 32'h0000_0013);
    push_fill(1);
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_word(32'h0000_0013, 0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        if (bus.imem_we && bus.imem_waddr == 7'd50) seen = 1'b1;
      end
      check("fill_reached_50", 32'(seen), 32'd1);
    end
    tick();
    pulse_start();
    check("fill_start_busy", 32'({busy, cpu_hold, done}), 32'b110);
    wait_end();
    expect_done("fill_start");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
